bcd_time_counter: RTL
=====================

Name: bcd_time_counter

Overview:
- Parametrised MM:SS BCD time counter for the stopwatch datapath, successor of the fixed 59:59 counter.
- Counts up or down on a 1 Hz tick and supports pause, manual and auto-step field adjust, and a configurable terminal policy (hold or wrap).
- Drives four BCD digits to the 7-segment display driver and raises a done pulse at terminal count.

Parameters:
- MAX_MIN, 59, upper limit of the minutes field (1..99); terminal count up is MAX_MIN:59.
- ADJ_STEP, 2, increment applied per tick_adj in auto-adjust mode (1..9).
- WRAP, 0, terminal policy: 0 = hold and auto-pause at terminal, 1 = wrap and keep running.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick_1hz  in  1  one-clk-wide count enable, 1 Hz
- tick_adj  in  1  one-clk-wide auto-adjust enable, 2 Hz
- pause_tgl  in  1  debounced one-clk pulse; toggles paused
- adj  in  1  level; adjust mode active
- sel  in  1  adjust target: 1 = seconds, 0 = minutes
- adj_man  in  1  1 = manual inc/dec, 0 = auto-step on tick_adj
- inc  in  1  one-clk pulse; manual +1
- dec  in  1  one-clk pulse; manual -1
- cnt_dn  in  1  1 = count down, 0 = count up
- sec_l  out  4  seconds units, BCD
- sec_h  out  4  seconds tens, BCD 0..5
- min_l  out  4  minutes units, BCD
- min_h  out  4  minutes tens, BCD
- paused  out  1  pause state
- done  out  1  one-clk pulse on reaching terminal count

Behaviour:
- Reset: all digits 0, paused=0, done=0. Reset overrides every other input in the same cycle.
- Priority, evaluated per clk: rst > adj > paused > count.
- pause_tgl inverts paused in any non-reset cycle, including during adj. The auto-pause rule below overrides it in the same cycle.
- Values are always kept legal: seconds 0..59, minutes 0..MAX_MIN, every nibble 0..9.
- Adjust, manual (adj=1, adj_man=1):
  - inc: selected field +1, wrapping 59->0 (sec) or MAX_MIN->0 (min).
  - dec: selected field -1, wrapping 0->59 or 0->MAX_MIN.
  - inc and dec together: no change.
  - The other field is never touched; no carry or borrow between fields.
- Adjust, auto (adj=1, adj_man=0):
  - On tick_adj, selected field += ADJ_STEP, modulo (field max + 1).
  - Example: sec 58 with step 2 -> 00; 59 -> 01.
- In adj mode, tick_1hz is ignored and done stays 0.
- Count up (adj=0, paused=0, cnt_dn=0), on tick_1hz:
  - BCD increment with carry sec_l->sec_h->min_l->min_h.
  - Reaching MAX_MIN:59 pulses done in that same update cycle.
  - At MAX_MIN:59 with a further tick: WRAP=0 holds the value; WRAP=1 goes to 00:00 with no extra done.
- Count down (cnt_dn=1), on tick_1hz:
  - BCD decrement with borrow.
  - The transition to 00:00 pulses done.
  - At 00:00 with a further tick: WRAP=0 holds; WRAP=1 loads MAX_MIN:59.
- Auto-pause (WRAP=0 only): in the cycle done pulses, paused is set to 1. Resuming via pause_tgl at terminal leaves the value held, and done is not re-pulsed.
- Resume from terminal: a value change (adjust or reset) clears terminal-hold status, so counting resumes normally.
- Switching cnt_dn mid-count: takes effect on the next tick, with no glitch on the digits.
- Latency: digit outputs are registered and change on the clk edge that samples the tick or pulse. done is registered and aligned with that digit update.
- No tick while paused has any effect. A tick arriving in the same cycle as pause_tgl is acted on using the pre-toggle paused value.

Test Plan:
- Reset, then 10 tick_1hz with cnt_dn=0 -> digits 00:10, paused=0, done never asserted.
- Preset 00:59 via manual adjust, then 1 tick -> 01:00. Preset MAX_MIN=59, 59:58, then 1 tick -> 59:59, done=1 for one clk, paused=1 (WRAP=0). Next tick -> still 59:59, no done.
- WRAP=1, MAX_MIN=9: 09:59 + tick -> 00:00 with done on the 09:59 arrival. cnt_dn=1 at 00:00 + tick -> 09:59.
- Count down from 01:00, tick -> 00:59. From 00:01, tick -> 00:00 with done pulse. Further ticks hold (WRAP=0).
- Manual adjust sel=1, sec=00: dec -> 59, min unchanged. inc+dec same cycle -> no change. sel=0, min=MAX_MIN: inc -> 00.
- Auto adjust ADJ_STEP=2, sel=1 from 57: three tick_adj -> 59, 01, 03. tick_1hz during adj ignored. pause_tgl pulse in the same cycle as tick_1hz while running -> that tick is counted, then paused=1.

Source files
------------

// File: rtl/bcd_time_counter.sv
// MM:SS BCD stopwatch counter: up/down counting on a 1 Hz tick, pause, manual and
// auto-step field adjust, and a hold-or-wrap terminal policy with a done pulse.
module bcd_time_counter #(
    parameter int MAX_MIN  = 59,
    parameter int ADJ_STEP = 2,
    parameter int WRAP     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_adj,
    input  logic       pause_tgl,
    input  logic       adj,
    input  logic       sel,
    input  logic       adj_man,
    input  logic       inc,
    input  logic       dec,
    input  logic       cnt_dn,
    output logic [3:0] sec_l,
    output logic [3:0] sec_h,
    output logic [3:0] min_l,
    output logic [3:0] min_h,
    output logic       paused,
    output logic       done
);

    localparam logic [3:0] MAX_H   = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_L   = 4'(MAX_MIN % 10);
    localparam logic [7:0] MIN_MOD = 8'(MAX_MIN + 1);
    localparam logic [7:0] STEP    = 8'(ADJ_STEP);

    logic [3:0] sec_l_q, sec_h_q, min_l_q, min_h_q;
    logic [3:0] sec_l_d, sec_h_d, min_l_d, min_h_d;
    logic       paused_q, paused_d;
    logic       done_q, done_d;

    logic [7:0] sec_v, min_v, fld_v, fld_mod, new_v;
    logic       min_at_max, at_top, at_zero;

    function automatic logic [7:0] add_mod(input logic [7:0] v, input logic [7:0] step,
                                           input logic [7:0] modulus);
        logic [8:0] sum;
        sum = {1'b0, v} + {1'b0, step};
        return 8'(sum % {1'b0, modulus});
    endfunction

    always_comb begin
        sec_l_d  = sec_l_q;
        sec_h_d  = sec_h_q;
        min_l_d  = min_l_q;
        min_h_d  = min_h_q;
        paused_d = paused_q ^ pause_tgl;
        done_d   = 1'b0;

        sec_v      = 8'(sec_h_q) * 8'd10 + 8'(sec_l_q);
        min_v      = 8'(min_h_q) * 8'd10 + 8'(min_l_q);
        fld_v      = sel ? sec_v : min_v;
        fld_mod    = sel ? 8'd60 : MIN_MOD;
        new_v      = fld_v;
        min_at_max = (min_h_q == MAX_H) && (min_l_q == MAX_L);
        at_top     = min_at_max && (sec_h_q == 4'd5) && (sec_l_q == 4'd9);
        at_zero    = (min_h_q == 4'd0) && (min_l_q == 4'd0) && (sec_h_q == 4'd0) && (sec_l_q == 4'd0);

        if (adj) begin
            // Field adjust works on the binary value of one field only; no carry between fields.
            if (adj_man) begin
                if (inc && !dec) new_v = add_mod(fld_v, 8'd1, fld_mod);
                else if (dec && !inc) new_v = (fld_v == 8'd0) ? fld_mod - 8'd1 : fld_v - 8'd1;
            end else if (tick_adj) begin
                new_v = add_mod(fld_v, STEP, fld_mod);
            end
            if (sel) begin
                sec_h_d = 4'(new_v / 8'd10);
                sec_l_d = 4'(new_v % 8'd10);
            end else begin
                min_h_d = 4'(new_v / 8'd10);
                min_l_d = 4'(new_v % 8'd10);
            end
        end else if (!paused_q && tick_1hz) begin
            if (!cnt_dn) begin
                if (at_top) begin
                    if (WRAP != 0) begin
                        sec_l_d = 4'd0;
                        sec_h_d = 4'd0;
                        min_l_d = 4'd0;
                        min_h_d = 4'd0;
                    end
                end else begin
                    done_d = min_at_max && (sec_h_q == 4'd5) && (sec_l_q == 4'd8);
                    if (sec_l_q != 4'd9) sec_l_d = sec_l_q + 4'd1;
                    else begin
                        sec_l_d = 4'd0;
                        if (sec_h_q != 4'd5) sec_h_d = sec_h_q + 4'd1;
                        else begin
                            sec_h_d = 4'd0;
                            if (min_l_q != 4'd9) min_l_d = min_l_q + 4'd1;
                            else begin
                                min_l_d = 4'd0;
                                min_h_d = min_h_q + 4'd1;
                            end
                        end
                    end
                end
            end else begin
                if (at_zero) begin
                    if (WRAP != 0) begin
                        sec_l_d = 4'd9;
                        sec_h_d = 4'd5;
                        min_l_d = MAX_L;
                        min_h_d = MAX_H;
                    end
                end else begin
                    done_d = (min_h_q == 4'd0) && (min_l_q == 4'd0) &&
                             (sec_h_q == 4'd0) && (sec_l_q == 4'd1);
                    if (sec_l_q != 4'd0) sec_l_d = sec_l_q - 4'd1;
                    else begin
                        sec_l_d = 4'd9;
                        if (sec_h_q != 4'd0) sec_h_d = sec_h_q - 4'd1;
                        else begin
                            sec_h_d = 4'd5;
                            if (min_l_q != 4'd0) min_l_d = min_l_q - 4'd1;
                            else begin
                                min_l_d = 4'd9;
                                min_h_d = min_h_q - 4'd1;
                            end
                        end
                    end
                end
            end
        end

        // Hold policy: reaching terminal stops the clock, overriding any toggle this cycle.
        if (done_d && (WRAP == 0)) paused_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_l_q  <= 4'd0;
            sec_h_q  <= 4'd0;
            min_l_q  <= 4'd0;
            min_h_q  <= 4'd0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sec_l_q  <= sec_l_d;
            sec_h_q  <= sec_h_d;
            min_l_q  <= min_l_d;
            min_h_q  <= min_h_d;
            paused_q <= paused_d;
            done_q   <= done_d;
        end
    end

    assign sec_l  = sec_l_q;
    assign sec_h  = sec_h_q;
    assign min_l  = min_l_q;
    assign min_h  = min_h_q;
    assign paused = paused_q;
    assign done   = done_q;

endmodule
